beta_backward: RTL

- Backward-recursion (beta) metric unit for the 8-state max-log-MAP SISO decoder; the mirror of the forward alpha unit.
- Accepts the same per-step branch-metric stream (init_branch1, init_branch2) in forward order and stores one whole block in a LIFO buffer.
- After the last step it replays the buffer in reverse, runs the beta recursion from a terminated trellis, and streams the normalized betas with the matching gammas to the LLR stage.

---
 rtl/siso_pkg.sv | 28 ++
 rtl/gamma_lifo_ram.sv | 30 +++
 rtl/beta_backward.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/siso_pkg.sv
// Shared types and arithmetic helpers for the max-log-MAP SISO metric units.
package siso_pkg;

    localparam int METRIC_W = 20;
    localparam int BRANCH_W = 16;

    localparam logic signed [METRIC_W-1:0] BETA_INIT_NEG = -20'sd128;
    localparam logic signed [METRIC_W-1:0] SAT_MAX       = 20'sd32767;
    localparam logic signed [METRIC_W-1:0] SAT_MIN       = -20'sd32768;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN_WAIT,
        DRAIN
    } beta_state_t;

    function automatic logic signed [BRANCH_W-1:0] sat16(input logic signed [METRIC_W-1:0] metric);
        if (metric > SAT_MAX) begin
            return 16'sh7fff;
        end else if (metric < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return metric[BRANCH_W-1:0];
        end
    endfunction

endpackage

// File: rtl/gamma_lifo_ram.sv
// Simple dual-port gamma store: one write port, one registered read port.
module gamma_lifo_ram #(
    parameter int DEPTH = 6144,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/beta_backward.sv
// Backward (beta) recursion unit: buffers one block of gammas, then replays
// them in reverse and streams normalized betas with the matching gammas.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no block in progress, ready for the first gamma pair
// FILL       | storing gamma pairs of the current block
// DRAIN_WAIT | block closed, read of step K-1 in flight, betas at init
// DRAIN      | one output per cycle, k = K-1 down to 0
module beta_backward
    import siso_pkg::*;
#(
    parameter int MAX_BLOCK = 6144,
    parameter int AW        = $clog2(MAX_BLOCK)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_branch,
    input  logic                       last_branch,
    input  logic signed [BRANCH_W-1:0] init_branch1,
    input  logic signed [BRANCH_W-1:0] init_branch2,
    output logic                       ready_in,
    output logic signed [BRANCH_W-1:0] beta_0,
    output logic signed [BRANCH_W-1:0] beta_1,
    output logic signed [BRANCH_W-1:0] beta_2,
    output logic signed [BRANCH_W-1:0] beta_3,
    output logic signed [BRANCH_W-1:0] beta_4,
    output logic signed [BRANCH_W-1:0] beta_5,
    output logic signed [BRANCH_W-1:0] beta_6,
    output logic signed [BRANCH_W-1:0] beta_7,
    output logic signed [BRANCH_W-1:0] gamma1_out,
    output logic signed [BRANCH_W-1:0] gamma2_out,
    output logic [AW-1:0]              step_idx,
    output logic                       valid_beta,
    output logic                       block_done
);

    beta_state_t                r_state;
    logic [AW-1:0]              r_wr_ptr;
    logic [AW-1:0]              r_step;
    logic signed [METRIC_W-1:0] r_beta [8];
    logic                       r_valid;
    logic                       r_done;

    logic                       w_accept;
    logic                       w_close;
    logic                       w_rd_en;
    logic [AW-1:0]              w_rd_addr;
    logic [2*BRANCH_W-1:0]      w_rd_data;
    logic signed [BRANCH_W-1:0] w_g1_raw;
    logic signed [BRANCH_W-1:0] w_g2_raw;
    logic signed [METRIC_W-1:0] w_g1;
    logic signed [METRIC_W-1:0] w_g2;
    logic signed [METRIC_W-1:0] w_n  [8];
    logic signed [METRIC_W-1:0] w_nb [8];

    function automatic logic signed [METRIC_W-1:0] max2(
        input logic signed [METRIC_W-1:0] a,
        input logic signed [METRIC_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

    assign ready_in = (r_state == IDLE) || (r_state == FILL);
    assign w_accept = valid_branch && ready_in;
    // The last buffer slot closes the block even without last_branch.
    assign w_close  = w_accept && (last_branch || (r_wr_ptr == AW'(MAX_BLOCK - 1)));

    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = r_step;
        if (r_state == DRAIN_WAIT) begin
            w_rd_en = 1'b1;
        end else if ((r_state == DRAIN) && (r_step != '0)) begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_step - AW'(1);
        end
    end

    gamma_lifo_ram #(
        .DEPTH (MAX_BLOCK),
        .AW    (AW),
        .DW    (2 * BRANCH_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({init_branch1, init_branch2}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign w_g1_raw = w_rd_data[2*BRANCH_W-1:BRANCH_W];
    assign w_g2_raw = w_rd_data[BRANCH_W-1:0];
    assign w_g1     = {{(METRIC_W-BRANCH_W){w_g1_raw[BRANCH_W-1]}}, w_g1_raw};
    assign w_g2     = {{(METRIC_W-BRANCH_W){w_g2_raw[BRANCH_W-1]}}, w_g2_raw};

    // Butterfly update to beta_k, then renormalize so state 0 stays at zero.
    always_comb begin
        w_n[0] = max2(r_beta[0] + w_g1, r_beta[4] - w_g1);
        w_n[1] = max2(r_beta[0] - w_g1, r_beta[4] + w_g1);
        w_n[2] = max2(r_beta[1] - w_g2, r_beta[5] + w_g2);
        w_n[3] = max2(r_beta[1] + w_g2, r_beta[5] - w_g2);
        w_n[4] = max2(r_beta[2] + w_g2, r_beta[6] - w_g2);
        w_n[5] = max2(r_beta[2] - w_g2, r_beta[6] + w_g2);
        w_n[6] = max2(r_beta[3] - w_g1, r_beta[7] + w_g1);
        w_n[7] = max2(r_beta[3] + w_g1, r_beta[7] - w_g1);
        for (int i = 0; i < 8; i++) begin
            w_nb[i] = w_n[i] - w_n[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_step   <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_beta[i] <= (i == 0) ? '0 : BETA_INIT_NEG;
            end
        end else begin
            case (r_state)
                IDLE, FILL: begin
                    if (w_accept) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        r_state  <= FILL;
                        if (w_close) begin
                            r_step  <= r_wr_ptr;
                            r_state <= DRAIN_WAIT;
                            for (int i = 0; i < 8; i++) begin
                                r_beta[i] <= (i == 0) ? '0 : BETA_INIT_NEG;
                            end
                        end
                    end
                end
                DRAIN_WAIT: begin
                    r_state <= DRAIN;
                    r_valid <= 1'b1;
                    r_done  <= (r_step == '0);
                end
                DRAIN: begin
                    for (int i = 0; i < 8; i++) begin
                        r_beta[i] <= w_nb[i];
                    end
                    if (r_step == '0) begin
                        r_state  <= IDLE;
                        r_valid  <= 1'b0;
                        r_done   <= 1'b0;
                        r_wr_ptr <= '0;
                    end else begin
                        r_step <= r_step - AW'(1);
                        r_done <= (r_step == AW'(1));
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign beta_0     = sat16(r_beta[0]);
    assign beta_1     = sat16(r_beta[1]);
    assign beta_2     = sat16(r_beta[2]);
    assign beta_3     = sat16(r_beta[3]);
    assign beta_4     = sat16(r_beta[4]);
    assign beta_5     = sat16(r_beta[5]);
    assign beta_6     = sat16(r_beta[6]);
    assign beta_7     = sat16(r_beta[7]);
    assign gamma1_out = w_g1_raw;
    assign gamma2_out = w_g2_raw;
    assign step_idx   = r_step;
    assign valid_beta = r_valid;
    assign block_done = r_done;

endmodule
